iq_mixer_accum: RTL and testbench

IQ_MIXER_ACCUM -- requirements
Module: iq_mixer_accum

---
 rtl/iq_mixer_accum.sv | 140 ++++++++++++++
 tb/tb_iq_mixer_accum.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/iq_mixer_accum.sv
// iq_mixer_accum: 3-stage ADC x SIN/COS mixer with windowed I/Q accumulation; optional saturation via IQ_MIXER_SAT_EN
module iq_mixer_accum #(
    parameter int DATA_BITS   = 16,
    parameter int ADC_BITS    = 12,
    parameter int ACC_BITS    = 32,
    parameter int WINDOW_BITS = 16
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          CE,
    input  logic signed [ADC_BITS-1:0]    ADC_VALUE,
    input  logic signed [DATA_BITS-1:0]   SIN,
    input  logic signed [DATA_BITS-1:0]   COS,
    input  logic        [WINDOW_BITS-1:0] WINDOW_LEN,
    output logic signed [ACC_BITS-1:0]    OUT_I,
    output logic signed [ACC_BITS-1:0]    OUT_Q,
    output logic                          OUT_VALID,
    output logic                          OUT_SAT
);
    localparam int PROD_BITS = ADC_BITS + DATA_BITS;
    localparam logic signed [ACC_BITS-1:0] ZERO = '0;

    logic [WINDOW_BITS-1:0] cnt, len_q, len_eff;
    logic at_start, at_end;

    logic signed [ADC_BITS-1:0]  s1_adc;
    logic signed [DATA_BITS-1:0] s1_sin, s1_cos;
    logic                        s1_first, s1_last;
    logic signed [PROD_BITS-1:0] adc_x, sin_x, cos_x;

    logic signed [PROD_BITS-1:0] s2_prod [2];
    logic                        s2_first, s2_last;

    logic signed [ACC_BITS-1:0] acc [2], acc_nx [2], base [2];

    // Window length is latched only at index 0 so mid-window changes wait for the next window
    always_comb begin
        at_start = cnt == '0;
        len_eff  = at_start ? ((WINDOW_LEN == '0) ? WINDOW_BITS'(1) : WINDOW_LEN) : len_q;
        at_end   = cnt == len_eff - WINDOW_BITS'(1);
    end

    // Sample index counter and latched window length
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt   <= '0;
            len_q <= '0;
        end else if (CE) begin
            cnt <= at_end ? '0 : cnt + WINDOW_BITS'(1);
            if (at_start) len_q <= len_eff;
        end
    end

    assign adc_x = PROD_BITS'(s1_adc);
    assign sin_x = PROD_BITS'(s1_sin);
    assign cos_x = PROD_BITS'(s1_cos);

    // S1 input capture with first/last tags, S2 full-precision products
    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_adc     <= '0;
            s1_sin     <= '0;
            s1_cos     <= '0;
            s1_first   <= 1'b0;
            s1_last    <= 1'b0;
            s2_prod    <= '{default: '0};
            s2_first   <= 1'b0;
            s2_last    <= 1'b0;
        end else if (CE) begin
            s1_adc     <= ADC_VALUE;
            s1_sin     <= SIN;
            s1_cos     <= COS;
            s1_first   <= at_start;
            s1_last    <= at_end;
            s2_prod[0] <= adc_x * cos_x;
            s2_prod[1] <= adc_x * sin_x;
            s2_first   <= s1_first;
            s2_last    <= s1_last;
        end
    end

`ifdef IQ_MIXER_SAT_EN
    localparam logic signed [ACC_BITS-1:0] ACC_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
    localparam logic signed [ACC_BITS-1:0] ACC_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};
    logic signed [ACC_BITS:0] sum [2];
    logic [1:0] clamp, clamp_nx, ovf;

    // Saturating accumulate; a clamped channel stays pinned until the next window starts
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            base[k]     = s2_first ? ZERO : acc[k];
            sum[k]      = (ACC_BITS+1)'(base[k]) + (ACC_BITS+1)'(s2_prod[k]);
            ovf[k]      = sum[k][ACC_BITS] != sum[k][ACC_BITS-1];
            acc_nx[k]   = (clamp[k] && !s2_first) ? acc[k] :
                          ovf[k] ? (sum[k][ACC_BITS] ? ACC_MIN : ACC_MAX) : sum[k][ACC_BITS-1:0];
            clamp_nx[k] = ovf[k] || (clamp[k] && !s2_first);
        end
    end

    // Per-window clamp flags and the registered saturation indication
    always_ff @(posedge CLK) begin
        if (RESET) begin
            clamp   <= '0;
            OUT_SAT <= 1'b0;
        end else if (CE) begin
            clamp <= clamp_nx;
            if (s2_last) OUT_SAT <= |clamp_nx;
        end
    end
`else
    // Wrapping accumulate modulo 2^ACC_BITS
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            base[k]   = s2_first ? ZERO : acc[k];
            acc_nx[k] = base[k] + ACC_BITS'(s2_prod[k]);
        end
    end

    assign OUT_SAT = 1'b0;
`endif

    // S3 accumulators and window result; OUT_VALID is a single-cycle pulse independent of CE
    always_ff @(posedge CLK) begin
        if (RESET) begin
            acc       <= '{default: '0};
            OUT_I     <= '0;
            OUT_Q     <= '0;
            OUT_VALID <= 1'b0;
        end else begin
            OUT_VALID <= CE && s2_last;
            if (CE) begin
                acc <= acc_nx;
                if (s2_last) begin
                    OUT_I <= acc_nx[0];
                    OUT_Q <= acc_nx[1];
                end
            end
        end
    end
endmodule

// File: tb/tb_iq_mixer_accum.sv
// tb_iq_mixer_accum: directed self-checking bench for iq_mixer_accum (honours IQ_MIXER_SAT_EN)
module tb_iq_mixer_accum;
    logic               CLK = 1'b0;
    logic               RESET, CE;
    logic signed [11:0] ADC_VALUE;
    logic signed [15:0] SIN, COS;
    logic        [15:0] WINDOW_LEN;
    logic signed [31:0] OUT_I, OUT_Q;
    logic               OUT_VALID, OUT_SAT;

    int n_checks = 0;
    int n_fail   = 0;
    int e, acc_n, pulses;

    iq_mixer_accum dut (
        .CLK(CLK), .RESET(RESET), .CE(CE), .ADC_VALUE(ADC_VALUE), .SIN(SIN), .COS(COS),
        .WINDOW_LEN(WINDOW_LEN), .OUT_I(OUT_I), .OUT_Q(OUT_Q), .OUT_VALID(OUT_VALID), .OUT_SAT(OUT_SAT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int edges);
        edges = 0;
        do begin
            tick();
            edges++;
        end while (!OUT_VALID && edges < budget);
        if (!OUT_VALID) check("valid_timeout", OUT_VALID, 1);
    endtask

    task automatic set_in(input int adc, input int s, input int c, input int wl);
        ADC_VALUE  = 12'(adc);
        SIN        = 16'(s);
        COS        = 16'(c);
        WINDOW_LEN = 16'(wl);
    endtask

    initial begin
        RESET = 1'b1;
        CE    = 1'b1;
        set_in(0, 0, 0, 0);
        tick();
        tick();
        check("rst_i", OUT_I, 0);
        check("rst_q", OUT_Q, 0);
        check("rst_valid", OUT_VALID, 0);
        check("rst_sat", OUT_SAT, 0);

        set_in(100, 32767, 0, 4);
        RESET = 1'b0;
        wait_valid(20, e);
        check("w4_latency", e, 6);
        check("w4_i", OUT_I, 0);
        check("w4_q", OUT_Q, 13106800);
        for (int n = 0; n < 2; n++) begin
            wait_valid(20, e);
            check("w4_period", e, 4);
            check("w4_q_rep", OUT_Q, 13106800);
        end
        tick();
        check("valid_one_cycle", OUT_VALID, 0);
        check("hold_q", OUT_Q, 13106800);

        do_reset();
        acc_n  = 0;
        pulses = 0;
        for (int n = 0; n < 60; n++) begin
            CE = 1'($urandom_range(0, 1));
            tick();
            if (CE) acc_n++;
            if (OUT_VALID) begin
                pulses++;
                check("ce_i", OUT_I, 0);
                check("ce_q", OUT_Q, 13106800);
            end
        end
        CE = 1'b1;
        while (acc_n % 4 != 0) begin
            tick();
            acc_n++;
            if (OUT_VALID) pulses++;
        end
        for (int n = 0; n < 2; n++) begin
            tick();
            if (OUT_VALID) pulses++;
        end
        CE = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            if (OUT_VALID) pulses++;
        end
        check("ce_pulses", pulses, acc_n / 4);
        check("ce_q_hold", OUT_Q, 13106800);

        CE = 1'b1;
        do_reset();
        wait_valid(20, e);
        check("pre_rst_q", OUT_Q, 13106800);
        RESET = 1'b1;
        CE    = 1'b0;
        tick();
        check("mid_rst_i", OUT_I, 0);
        check("mid_rst_q", OUT_Q, 0);
        check("mid_rst_valid", OUT_VALID, 0);
        check("mid_rst_sat", OUT_SAT, 0);
        RESET = 1'b0;
        CE    = 1'b1;
        set_in(7, 3, -5, 4);
        wait_valid(20, e);
        check("post_rst_latency", e, 6);
        check("post_rst_i", OUT_I, -140);
        check("post_rst_q", OUT_Q, 84);

        do_reset();
        set_in(10, 20, 30, 4);
        tick();
        tick();
        WINDOW_LEN = 16'd8;
        wait_valid(20, e);
        check("wl_first_close", e, 4);
        check("wl4_i", OUT_I, 1200);
        check("wl4_q", OUT_Q, 800);
        WINDOW_LEN = 16'd0;
        wait_valid(20, e);
        check("wl8_period", e, 8);
        check("wl8_i", OUT_I, 2400);
        check("wl8_q", OUT_Q, 1600);
        wait_valid(20, e);
        check("wl0_period", e, 1);
        check("wl0_i", OUT_I, 300);
        check("wl0_q", OUT_Q, 200);
        ADC_VALUE = -12'sd3;
        for (int n = 0; n < 3; n++) begin
            wait_valid(20, e);
            check("wl0_every", e, 1);
        end
        check("wl0_new_i", OUT_I, -90);
        check("wl0_new_q", OUT_Q, -60);

        do_reset();
        set_in(-2048, 32767, -32768, 2);
        wait_valid(20, e);
        check("max_i", OUT_I, 134217728);
        check("max_q", OUT_Q, -134213632);

        do_reset();
        WINDOW_LEN = 16'd1;
        wait_valid(20, e);
        check("corner_prod", OUT_I, 67108864);

        do_reset();
        WINDOW_LEN = 16'd16;
        wait_valid(40, e);
        check("w16_i", OUT_I, 1073741824);
        check("w16_q", OUT_Q, -1073709056);
        check("w16_sat", OUT_SAT, 0);

        do_reset();
        WINDOW_LEN = 16'd32;
        wait_valid(60, e);
        check("w32_q", OUT_Q, -2147418112);
`ifdef IQ_MIXER_SAT_EN
        check("w32_i", OUT_I, 2147483647);
        check("w32_sat", OUT_SAT, 1);
`else
        check("w32_i", OUT_I, -64'sd2147483648);
        check("w32_sat", OUT_SAT, 0);
`endif

        do_reset();
        set_in(-2048, 0, -32768, 33);
        repeat (32) tick();
        COS = 16'sd32767;
        wait_valid(20, e);
        check("w33_latency", e, 3);
        check("w33_q", OUT_Q, 0);
`ifdef IQ_MIXER_SAT_EN
        check("w33_i_held", OUT_I, 2147483647);
        check("w33_sat", OUT_SAT, 1);
`else
        check("w33_i_wrap", OUT_I, 2080376832);
        check("w33_sat", OUT_SAT, 0);
`endif
        tick();
        check("w33_valid_drop", OUT_VALID, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
